// File: rtl/exec_wb_sequencer_if.sv
// Bundles the sequencer's instruction, ALU, writeback, flag and debug signals.
// An instruction transfers on a rising edge where instr_valid && instr_ready are both high;
// the sequencer latches every field at that edge, so the fields may change afterwards.
interface exec_wb_sequencer_if #(
    parameter int DW   = 16,
    parameter int RA_W = 3
);
    logic            instr_valid;
    logic            instr_ready;
    logic [2:0]      instr_op;
    logic            instr_cmp;
    logic [RA_W-1:0] instr_rd;
    logic [RA_W-1:0] instr_ra;
    logic [RA_W-1:0] instr_rb;
    logic            instr_imm_en;
    logic [DW-1:0]   instr_imm;

    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [2:0]      alu_op;
    logic            alu_en;
    logic            alu_setflag;
    logic [DW-1:0]   alu_r;
    logic            alu_z;
    logic            alu_n;

    logic            wb_valid;
    logic [RA_W-1:0] wb_rd;
    logic [DW-1:0]   wb_data;
    logic            flag_z;
    logic            flag_n;

    logic [RA_W-1:0] dbg_addr;
    logic [DW-1:0]   dbg_data;

    modport slave (
        input  instr_valid, instr_op, instr_cmp, instr_rd, instr_ra, instr_rb,
               instr_imm_en, instr_imm, alu_r, alu_z, alu_n, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, alu_en, alu_setflag,
               wb_valid, wb_rd, wb_data, flag_z, flag_n, dbg_data
    );

    modport master (
        output instr_valid, instr_op, instr_cmp, instr_rd, instr_ra, instr_rb,
               instr_imm_en, instr_imm, alu_r, alu_z, alu_n, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, alu_en, alu_setflag,
               wb_valid, wb_rd, wb_data, flag_z, flag_n, dbg_data
    );
endinterface

// File: rtl/exec_wb_sequencer.sv
// Four-cycle execute/writeback sequencer around a combinational ALU:
// IDLE (accept) -> OPRD (load operands) -> EXEC (ALU enabled, capture) -> WB (retire).
module exec_wb_sequencer #(
    parameter int DW   = 16,
    parameter int RA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    exec_wb_sequencer_if.slave bus,
    output logic [1:0]        o_state
);
    localparam int NREG = 2 ** RA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPRD = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t          r_state;

    logic            r_cmp;
    logic [RA_W-1:0] r_rd;
    logic [RA_W-1:0] r_ra;
    logic [RA_W-1:0] r_rb;
    logic            r_imm_en;
    logic [DW-1:0]   r_imm;
    logic [2:0]      r_op;

    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [2:0]      r_alu_op;

    logic [DW-1:0]   r_res;
    logic            r_res_z;
    logic            r_res_n;

    logic            r_wb_valid;
    logic [RA_W-1:0] r_wb_rd;
    logic            r_flag_z;
    logic            r_flag_n;

    logic [DW-1:0]   r_regs [NREG];

    logic [DW-1:0]   w_src_a;
    logic [DW-1:0]   w_src_b;
    logic            w_accept;

    // r0 is never written, but reads are forced to zero so it stays zero regardless.
    assign w_src_a  = (r_ra == '0) ? '0 : r_regs[r_ra];
    assign w_src_b  = r_imm_en ? r_imm : ((r_rb == '0) ? '0 : r_regs[r_rb]);
    assign w_accept = (r_state == S_IDLE) && bus.instr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmp      <= 1'b0;
            r_rd       <= '0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_imm_en   <= 1'b0;
            r_imm      <= '0;
            r_op       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res      <= '0;
            r_res_z    <= 1'b0;
            r_res_n    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_flag_z   <= 1'b0;
            r_flag_n   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmp    <= bus.instr_cmp;
                        r_rd     <= bus.instr_rd;
                        r_ra     <= bus.instr_ra;
                        r_rb     <= bus.instr_rb;
                        r_imm_en <= bus.instr_imm_en;
                        r_imm    <= bus.instr_imm;
                        r_op     <= bus.instr_op;
                        r_state  <= S_OPRD;
                    end
                end
                S_OPRD: begin
                    r_alu_a  <= w_src_a;
                    r_alu_b  <= w_src_b;
                    r_alu_op <= r_op;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_res      <= bus.alu_r;
                    r_res_z    <= bus.alu_z;
                    r_res_n    <= bus.alu_n;
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_cmp ? '0 : r_rd;
                    r_state    <= S_WB;
                end
                S_WB: begin
                    // Compares only touch the flags; ordinary ops only touch the register file.
                    if (r_cmp) begin
                        r_flag_z <= r_res_z;
                        r_flag_n <= r_res_n;
                    end else if (r_rd != '0) begin
                        r_regs[r_rd] <= r_res;
                    end
                    r_wb_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_en      = (r_state == S_EXEC);
    assign bus.alu_setflag = (r_state == S_EXEC) && r_cmp;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_res;
    assign bus.flag_z      = r_flag_z;
    assign bus.flag_n      = r_flag_n;
    assign bus.dbg_data    = (bus.dbg_addr == '0) ? '0 : r_regs[bus.dbg_addr];
    assign o_state         = r_state;
endmodule

// File: tb/tb_exec_wb_sequencer.sv
// Directed bench for exec_wb_sequencer with a behavioural ALU attached to its ALU port.
module tb_exec_wb_sequencer;
    localparam int DW   = 16;
    localparam int RA_W = 3;

    logic       clk;
    logic       rst;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];

    logic [DW-1:0] alu_f;

    exec_wb_sequencer_if #(.DW(DW), .RA_W(RA_W)) bus_if ();

    exec_wb_sequencer #(.DW(DW), .RA_W(RA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .o_state (state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ALU outputs are gated by its enables, so a missing enable shows up as a zero result.
    always_comb begin
        alu_f = '0;
        case (bus_if.alu_op)
            3'b000:  alu_f = bus_if.alu_a + bus_if.alu_b;
            3'b111:  alu_f = bus_if.alu_a - bus_if.alu_b;
            3'b100:  alu_f = bus_if.alu_a & bus_if.alu_b;
            3'b010:  alu_f = bus_if.alu_a | bus_if.alu_b;
            3'b001:  alu_f = ~bus_if.alu_a;
            default: alu_f = '0;
        endcase
        bus_if.alu_r = bus_if.alu_en ? alu_f : '0;
        bus_if.alu_z = bus_if.alu_setflag && (bus_if.alu_a == bus_if.alu_b);
        bus_if.alu_n = bus_if.alu_setflag && (bus_if.alu_a < bus_if.alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [RA_W-1:0] addr, input logic [DW-1:0] exp);
        bus_if.dbg_addr = addr;
        #1;
        chk($sformatf("reg_r%0d", addr), bus_if.dbg_data, exp);
    endtask

    // Called at a negedge while IDLE; returns at the negedge of cycle T+4 (IDLE again).
    task automatic do_instr(input string name, input logic [2:0] op, input logic cmp,
                            input logic [RA_W-1:0] rd, input logic [RA_W-1:0] ra,
                            input logic [RA_W-1:0] rb, input logic imm_en,
                            input logic [DW-1:0] imm, input logic [DW-1:0] exp_data);
        logic [DW-1:0] exp_v;
        exp_q.push_back(exp_data);
        chk({name, "_ready_idle"}, bus_if.instr_ready, 1);
        bus_if.instr_op     = op;
        bus_if.instr_cmp    = cmp;
        bus_if.instr_rd     = rd;
        bus_if.instr_ra     = ra;
        bus_if.instr_rb     = rb;
        bus_if.instr_imm_en = imm_en;
        bus_if.instr_imm    = imm;
        bus_if.instr_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.instr_valid  = 1'b0;
        bus_if.instr_op     = 3'($urandom_range(0, 7));
        bus_if.instr_cmp    = 1'($urandom_range(0, 1));
        bus_if.instr_rd     = 3'($urandom_range(0, 7));
        bus_if.instr_ra     = 3'($urandom_range(0, 7));
        bus_if.instr_rb     = 3'($urandom_range(0, 7));
        bus_if.instr_imm_en = 1'($urandom_range(0, 1));
        bus_if.instr_imm    = 16'($urandom_range(0, 65535));
        chk({name, "_oprd_ready"}, bus_if.instr_ready, 0);
        chk({name, "_oprd_en"}, bus_if.alu_en, 0);
        chk({name, "_oprd_wbv"}, bus_if.wb_valid, 0);
        @(negedge clk);
        chk({name, "_exec_en"}, bus_if.alu_en, 1);
        chk({name, "_exec_setflag"}, bus_if.alu_setflag, cmp);
        chk({name, "_exec_wbv"}, bus_if.wb_valid, 0);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        chk({name, "_wb_valid"}, bus_if.wb_valid, 1);
        chk({name, "_wb_data"}, bus_if.wb_data, exp_v);
        chk({name, "_wb_rd"}, bus_if.wb_rd, cmp ? 3'd0 : rd);
        chk({name, "_wb_en"}, bus_if.alu_en, 0);
        @(negedge clk);
        chk({name, "_post_wbv"}, bus_if.wb_valid, 0);
        chk({name, "_post_ready"}, bus_if.instr_ready, 1);
    endtask

    initial begin
        rst                 = 1'b1;
        bus_if.instr_valid  = 1'b0;
        bus_if.instr_op     = '0;
        bus_if.instr_cmp    = 1'b0;
        bus_if.instr_rd     = '0;
        bus_if.instr_ra     = '0;
        bus_if.instr_rb     = '0;
        bus_if.instr_imm_en = 1'b0;
        bus_if.instr_imm    = '0;
        bus_if.dbg_addr     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        chk("rst_ready", bus_if.instr_ready, 1);
        chk("rst_state", state, 0);
        chk("rst_flag_z", bus_if.flag_z, 0);
        chk("rst_flag_n", bus_if.flag_n, 0);
        chk("rst_wbv", bus_if.wb_valid, 0);
        chk("rst_wb_data", bus_if.wb_data, 0);
        chk("rst_alu_a", bus_if.alu_a, 0);
        chk("rst_alu_en", bus_if.alu_en, 0);
        for (int i = 1; i < 8; i++) chk_reg(3'(i), 16'h0000);
        @(negedge clk);

        // 2: add immediate, then register-register add
        do_instr("add_imm_r1", 3'b000, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 16'd5);
        do_instr("add_r2", 3'b000, 1'b0, 3'd2, 3'd1, 3'd1, 1'b0, 16'hAAAA, 16'd10);
        chk_reg(3'd1, 16'd5);
        chk_reg(3'd2, 16'd10);
        chk("add_flag_z", bus_if.flag_z, 0);
        chk("add_flag_n", bus_if.flag_n, 0);
        @(negedge clk);

        // 3: subtract wrap and NOT
        do_instr("set_r1", 3'b000, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd3, 16'd3);
        do_instr("set_r2", 3'b000, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5, 16'd5);
        do_instr("sub_r3", 3'b111, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'hFFFE);
        do_instr("not_r4", 3'b001, 1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000, 16'hFFFF);
        chk_reg(3'd3, 16'hFFFE);
        chk_reg(3'd4, 16'hFFFF);
        @(negedge clk);

        // 4: compares
        do_instr("cmp_lt", 3'b111, 1'b1, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 16'hFFFE);
        chk("cmp_lt_z", bus_if.flag_z, 0);
        chk("cmp_lt_n", bus_if.flag_n, 1);
        chk_reg(3'd1, 16'd3);
        @(negedge clk);
        do_instr("cmp_eq", 3'b111, 1'b1, 3'd2, 3'd2, 3'd2, 1'b0, 16'h0000, 16'h0000);
        chk("cmp_eq_z", bus_if.flag_z, 1);
        chk("cmp_eq_n", bus_if.flag_n, 0);
        chk_reg(3'd2, 16'd5);
        @(negedge clk);
        do_instr("cmp_gt", 3'b111, 1'b1, 3'd3, 3'd2, 3'd1, 1'b0, 16'h0000, 16'h0002);
        chk("cmp_gt_z", bus_if.flag_z, 0);
        chk("cmp_gt_n", bus_if.flag_n, 0);
        chk_reg(3'd3, 16'hFFFE);
        @(negedge clk);

        // 5: r0 write discarded, undefined op, flags held by non-compares
        do_instr("cmp_set_n", 3'b111, 1'b1, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000, 16'hFFFE);
        do_instr("add_r0", 3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 16'd7, 16'd7);
        chk_reg(3'd0, 16'h0000);
        @(negedge clk);
        do_instr("set_r7", 3'b000, 1'b0, 3'd7, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h1234);
        do_instr("undef_r7", 3'b011, 1'b0, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000);
        do_instr("and_r6", 3'b100, 1'b0, 3'd6, 3'd3, 3'd2, 1'b0, 16'h0000, 16'h0004);
        do_instr("or_r5", 3'b010, 1'b0, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0100, 16'h0103);
        chk_reg(3'd7, 16'h0000);
        chk_reg(3'd6, 16'h0004);
        chk_reg(3'd5, 16'h0103);
        chk("hold_flag_z", bus_if.flag_z, 0);
        chk("hold_flag_n", bus_if.flag_n, 1);
        @(negedge clk);

        // 6: reset during EXEC aborts the write
        do_instr("set_r5", 3'b000, 1'b0, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9, 16'd9);
        bus_if.instr_op     = 3'b000;
        bus_if.instr_cmp    = 1'b0;
        bus_if.instr_rd     = 3'd5;
        bus_if.instr_ra     = 3'd0;
        bus_if.instr_imm_en = 1'b1;
        bus_if.instr_imm    = 16'd3;
        bus_if.instr_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec_en", bus_if.alu_en, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_ready", bus_if.instr_ready, 1);
        chk("abort_wbv", bus_if.wb_valid, 0);
        chk("abort_flag_n", bus_if.flag_n, 0);
        chk_reg(3'd5, 16'h0000);
        @(negedge clk);
        chk("abort_wbv_late", bus_if.wb_valid, 0);
        chk_reg(3'd5, 16'h0000);
        @(negedge clk);

        // 6: valid held high, r6 += 1 each instruction
        bus_if.instr_op     = 3'b000;
        bus_if.instr_cmp    = 1'b0;
        bus_if.instr_rd     = 3'd6;
        bus_if.instr_ra     = 3'd6;
        bus_if.instr_rb     = 3'd0;
        bus_if.instr_imm_en = 1'b1;
        bus_if.instr_imm    = 16'd1;
        bus_if.instr_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("stream_ready_c%0d", i), bus_if.instr_ready, (i % 4) == 0);
            chk($sformatf("stream_wbv_c%0d", i), bus_if.wb_valid, (i % 4) == 3);
            @(negedge clk);
        end
        bus_if.instr_valid = 1'b0;
        chk("stream_end_ready", bus_if.instr_ready, 1);
        chk_reg(3'd6, 16'd3);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/exec_wb_sequencer.md
Name: exec_wb_sequencer

Overview:
Execute/writeback sequencer that sits directly around the combinational ALU. It accepts one decoded instruction at a time over a valid/ready handshake and reads its operands from an internal register file. It drives the ALU's a/b/op/en/setflag inputs, captures r/z/n, then writes the result back and holds the architectural Z/N flags. Throughput is one instruction per 4 cycles; no pipelining.

Parameters:
DW, 16, datapath width; must match the ALU width.
RA_W, 3, register address width; NREG = 2**RA_W registers, with r0 hardwired to zero.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
instr_valid  input  1  upstream presents an instruction.
instr_ready  output  1  high only in IDLE.
instr_op  input  3  ALU op: ADD 000, SUB 111, AND 100, OR 010, NOT 001; other codes give result 0.
instr_cmp  input  1  compare: set flags only, no register write.
instr_rd  input  RA_W  destination register.
instr_ra  input  RA_W  source A register.
instr_rb  input  RA_W  source B register.
instr_imm_en  input  1  use instr_imm instead of reg[rb] as B.
instr_imm  input  DW  immediate operand.
alu_a  output  DW  registered A operand to ALU.
alu_b  output  DW  registered B operand to ALU.
alu_op  output  3  registered op to ALU.
alu_en  output  1  ALU enable.
alu_setflag  output  1  ALU flag-compute enable.
alu_r  input  DW  ALU result.
alu_z  input  1  ALU zero/equal flag (a == b).
alu_n  input  1  ALU less-than flag (unsigned a < b).
wb_valid  output  1  one-cycle pulse when an instruction retires.
wb_rd  output  RA_W  retired destination register (0 for cmp).
wb_data  output  DW  retired result.
flag_z  output  1  architectural Z flag.
flag_n  output  1  architectural N flag.
dbg_addr  input  RA_W  debug read address.
dbg_data  output  DW  combinational read of reg[dbg_addr]; returns 0 when dbg_addr is 0.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - State goes to IDLE; all registers r0..rN-1 clear to 0.
  - alu_a, alu_b, alu_op, alu_en, alu_setflag, wb_valid, wb_rd, wb_data, flag_z and flag_n all clear to 0.
  - instr_ready is 1 on the first cycle after reset is released.
  - Reset in any state aborts the in-flight instruction: no register write, no flag update, no wb_valid.
- FSM, with accept at edge T:
  - IDLE: instr_ready=1. On instr_valid, latch cmp, rd, op and operand selection, then go to OPRD.
  - OPRD (cycle after T): load alu_a=reg[ra] and alu_b = imm_en ? imm : reg[rb]; load alu_op. Go to EXEC.
  - EXEC: alu_en=1 and alu_setflag=cmp, both combinational from state. At the end of EXEC, capture alu_r, alu_z and alu_n into internal result registers. Go to WB.
  - WB: wb_valid=1 for exactly this cycle, with wb_data = captured result and wb_rd = rd (0 if cmp).
    - Non-cmp: at the WB edge, reg[rd] <= result, except that a write to r0 is discarded.
    - Cmp: at the WB edge, flag_z/flag_n <= captured z/n and the register file is unchanged.
    - Non-cmp instructions never change the flags.
    - Go to IDLE.
- Timing:
  - wb_valid is high in cycle T+3 and instr_ready is high again in cycle T+4.
  - A back-to-back instruction reads values written by the previous WB, so there is no hazard.
- Handshake: instructions are accepted only when instr_valid && instr_ready. instr_* may change freely once accepted, because all needed fields are latched.
- Arithmetic: results are DW bits and wrap modulo 2**DW; there is no carry out. SUB of a smaller minus a larger value wraps. Compares are unsigned.
- Reading r0 as a source always yields 0.
- alu_en and alu_setflag are 0 in every state other than EXEC.

Test Plan:
1. Reset, then dbg reads r1..r7 -> all 0; flag_z=0, flag_n=0; instr_ready=1 in the first cycle after rst drops.
2. ADD imm r1=r0+5, then ADD r2=r1+r1 -> each wb_valid lands exactly 3 cycles after accept; r1=5, r2=10; flags stay 0.
3. Set r1=3 and r2=5 via imm, then SUB r3=r1-r2 -> r3=16'hFFFE (wrap); NOT r4=r0 -> 16'hFFFF.
4. Cmp r1(3) vs r2(5) -> flag_n=1, flag_z=0, wb_rd=0, no register changes; then cmp r2 vs r2 -> flag_z=1, flag_n=0; then cmp r2 vs r1 -> both 0.
5. ADD imm with rd=0 and imm=7 -> wb_valid pulses with wb_data=7, but dbg r0 stays 0; undefined op 011 -> wb_data=0 written to rd.
6. Assert rst during EXEC of a write to r5 holding 9 -> r5=0, no wb_valid, IDLE next cycle; instr_valid held high continuously -> accept spacing is exactly 4 cycles.
